// File: rtl/neuron_vote_window.sv
// neuron_vote_window: counts spike samples over fixed windows and publishes a count plus a hysteresis decision
module neuron_vote_window #(
  parameter int WINDOW  = 16,
  parameter int HIGH_TH = 12,
  parameter int LOW_TH  = 4,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y_in,
  input  logic             clear,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_valid,
  output logic             dec,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] phase
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, phase_q, phase_d, res_count_q, res_count_d, fin;
  logic res_valid_q, res_valid_d, dec_q, dec_d, overrun_q, overrun_d, commit, load;
  // next-state: clear beats en; commit closes a window and either publishes or drops the count
  always_comb begin
    fin = acc_q + CNT_W'(y_in);
    commit = en && !clear && state_q == ACC && phase_q == CNT_W'(WINDOW - 1);
    load = commit && (!res_valid_q || res_ready);
    state_d = clear ? IDLE : en ? ACC : state_q;
    acc_d = clear ? '0 : !en ? acc_q : commit ? '0 : fin;
    phase_d = clear ? '0 : !en ? phase_q : commit ? '0 : phase_q + 1'b1;
    res_count_d = load ? fin : res_count_q;
    res_valid_d = load ? 1'b1 : res_ready ? 1'b0 : res_valid_q;
    overrun_d = clear ? 1'b0 : (commit && res_valid_q && !res_ready) ? 1'b1 : overrun_q;
    dec_d = !commit ? dec_q : fin >= CNT_W'(HIGH_TH) ? 1'b1 : fin <= CNT_W'(LOW_TH) ? 1'b0 : dec_q;
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      phase_q <= '0;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
      dec_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      phase_q <= phase_d;
      res_count_q <= res_count_d;
      res_valid_q <= res_valid_d;
      dec_q <= dec_d;
      overrun_q <= overrun_d;
    end
  end
  assign res_count = res_count_q;
  assign res_valid = res_valid_q;
  assign dec = dec_q;
  assign overrun = overrun_q;
  assign busy = state_q == ACC;
  assign phase = phase_q;
endmodule

// File: tb/tb_neuron_vote_window.sv
// tb_neuron_vote_window: directed vector table plus hand-written window sequences
module tb_neuron_vote_window;
  logic clk = 0, rst = 1, en = 0, y_in = 0, clear = 0, res_ready = 0;
  logic [4:0] res_count, phase;
  logic res_valid, dec, overrun, busy;
  int errors = 0, checks = 0;

  neuron_vote_window dut (
    .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clear(clear), .res_ready(res_ready),
    .res_count(res_count), .res_valid(res_valid), .dec(dec), .overrun(overrun),
    .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  typedef struct {
    logic en, y, clr, rdy;
    int ph, bz, rv, cnt, dc, ov;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int ph, input int bz, input int rv,
                         input int cnt, input int dc, input int ov);
    chk({name, ".phase"}, int'(phase), ph);
    chk({name, ".busy"}, int'(busy), bz);
    chk({name, ".res_valid"}, int'(res_valid), rv);
    chk({name, ".res_count"}, int'(res_count), cnt);
    chk({name, ".dec"}, int'(dec), dc);
    chk({name, ".overrun"}, int'(overrun), ov);
  endtask

  task automatic cyc(input logic e, input logic y, input logic c, input logic r);
    @(negedge clk);
    en = e; y_in = y; clear = c; res_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic window(input int ones, input logic r_body, input logic r_last);
    for (int i = 0; i < 16; i++) cyc(1'b1, i < ones, 1'b0, i == 15 ? r_last : r_body);
  endtask

  initial begin
    tbl[0] = '{en:0, y:0, clr:0, rdy:0, ph:0, bz:0, rv:0, cnt:0, dc:0, ov:0};
    tbl[1] = '{en:1, y:1, clr:0, rdy:0, ph:1, bz:1, rv:0, cnt:0, dc:0, ov:0};
    tbl[2] = '{en:0, y:1, clr:0, rdy:0, ph:1, bz:1, rv:0, cnt:0, dc:0, ov:0};
    tbl[3] = '{en:1, y:0, clr:0, rdy:0, ph:2, bz:1, rv:0, cnt:0, dc:0, ov:0};
    tbl[4] = '{en:1, y:1, clr:1, rdy:0, ph:0, bz:0, rv:0, cnt:0, dc:0, ov:0};
    tbl[5] = '{en:1, y:1, clr:0, rdy:0, ph:1, bz:1, rv:0, cnt:0, dc:0, ov:0};
    tbl[6] = '{en:0, y:0, clr:1, rdy:0, ph:0, bz:0, rv:0, cnt:0, dc:0, ov:0};

    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].en, tbl[i].y, tbl[i].clr, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].ph, tbl[i].bz, tbl[i].rv, tbl[i].cnt, tbl[i].dc, tbl[i].ov);
    end

    window(13, 1, 1);
    chk_all("win13", 0, 1, 1, 13, 1, 0);
    window(8, 1, 1);
    chk_all("win8_hyst", 0, 1, 1, 8, 1, 0);
    window(3, 1, 1);
    chk_all("win3_low", 0, 1, 1, 3, 0, 0);
    window(10, 0, 1);
    chk_all("commit_with_ready", 0, 1, 1, 10, 0, 0);

    cyc(0, 0, 0, 1);
    chk_all("consume", 0, 1, 0, 10, 0, 0);
    window(5, 0, 0);
    chk_all("win5_held", 0, 1, 1, 5, 0, 0);
    window(9, 0, 0);
    chk_all("win9_dropped", 0, 1, 1, 5, 0, 1);
    window(12, 0, 0);
    chk_all("win12_dropped_dec", 0, 1, 1, 5, 1, 1);
    cyc(0, 0, 0, 1);
    chk_all("consume_after_drop", 0, 1, 0, 5, 1, 1);
    cyc(0, 0, 1, 0);
    chk_all("clear_overrun", 0, 0, 0, 5, 1, 0);

    begin
      int k = 0;
      for (int i = 0; i < 32; i++) begin
        cyc(i % 2 == 0, 1'b1, 1'b0, 1'b0);
        if (i % 2 == 0) k++;
        chk($sformatf("toggle%0d.phase", i), int'(phase), k % 16);
        chk($sformatf("toggle%0d.res_valid", i), int'(res_valid), k >= 16 ? 1 : 0);
      end
    end
    chk_all("toggle_end", 0, 1, 1, 16, 1, 0);

    cyc(0, 0, 1, 1);
    chk_all("clear_consume", 0, 0, 0, 16, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0);
    chk_all("phase7", 7, 1, 0, 16, 1, 0);
    cyc(1, 1, 1, 0);
    chk_all("clear_at7", 0, 0, 0, 16, 1, 0);
    window(2, 0, 0);
    chk_all("fresh_after_clear", 0, 1, 1, 2, 0, 0);

    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
    chk_all("phase10", 10, 1, 1, 2, 0, 0);
    #2 rst = 1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    rst = 0;
    window(4, 1, 1);
    chk_all("after_reset", 0, 1, 1, 4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neuron_vote_window.md
NEURON_VOTE_WINDOW -- requirements
Module: neuron_vote_window

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the number of enabled samples per voting window (legal range 2..255).
REQ-002 SHALL have parameter HIGH_TH, default 12, the window count at or above which the decision goes high.
REQ-003 SHALL have parameter LOW_TH, default 4, the window count at or below which the decision goes low; LOW_TH < HIGH_TH <= WINDOW is required.
REQ-004 SHALL have derived localparam CNT_W = clog2(WINDOW+1), the count width (5 at default).
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 en  input  1  sample strobe; y_in is counted only in cycles where en=1.
REQ-008 y_in  input  1  spike bit from the final neuron of the layer.
REQ-009 clear  input  1  synchronous abort of the current window.
REQ-010 res_ready  input  1  consumer accepts res_count when res_valid=1.
REQ-011 res_count  output  CNT_W  number of y_in=1 samples in the last committed window.
REQ-012 res_valid  output  1  res_count holds an unconsumed result.
REQ-013 dec  output  1  hysteresis class decision.
REQ-014 overrun  output  1  sticky flag: a window result was dropped.
REQ-015 busy  output  1  high while state is ACC.
REQ-016 phase  output  CNT_W  index of the next sample within the window (0..WINDOW-1).

Function
REQ-017 SHALL implement two states, IDLE and ACC, plus an internal CNT_W-bit accumulator acc.
REQ-018 IDLE: phase=0, acc=0; en=1 -> ACC, and that sample is counted (acc=y_in, phase=1).
REQ-019 ACC with en=1 and phase<WINDOW-1: acc+=y_in, phase+=1.
REQ-020 ACC with en=0: acc and phase hold; the window pauses, never times out.
REQ-021 ACC with en=1 and phase=WINDOW-1 (commit): final=acc+y_in; acc=0, phase=0, state stays ACC.
REQ-022 acc and final never exceed WINDOW, so no wrap-around occurs at CNT_W bits.
REQ-023 On commit, if res_valid=0 or res_ready=1: res_count<=final, res_valid<=1 (the result becomes visible the cycle after the final sample).
REQ-024 On commit, if res_valid=1 and res_ready=0: res_count is kept, the new result is dropped, overrun<=1.
REQ-025 With no commit, res_valid=1 and res_ready=1: res_valid<=0 and res_count holds its value.
REQ-026 On commit, dec<=1 if final>=HIGH_TH, dec<=0 if final<=LOW_TH, otherwise dec holds; dec updates even when the result is dropped.
REQ-027 clear=1 takes priority over en: state<=IDLE, acc<=0, phase<=0, overrun<=0; res_count, res_valid and dec are unaffected; a res_ready handshake in the same cycle still completes.
REQ-028 busy=1 exactly when the state is ACC; all outputs are registered.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, acc=0, phase=0, res_count=0, res_valid=0, dec=0, overrun=0, busy=0, regardless of clk.
REQ-030 Reset asserted mid-window SHALL discard the partial window; the first en=1 after release starts a fresh window at phase 0.

Verification
REQ-031 Defaults, en=1 for 16 cycles with y_in=1 on 13 of them, res_ready=1 -> res_valid=1 with res_count=13 the cycle after the 16th sample; dec=1.
REQ-032 Continuing from REQ-031, the next window has 8 ones -> res_count=8, dec stays 1 (hysteresis); the following window has 3 ones -> dec=0.
REQ-033 res_ready=0 across two full windows (counts 5 then 9) -> res_count stays 5, overrun=1; then res_ready=1 for one cycle -> res_valid=0; then clear=1 -> overrun=0.
REQ-034 en toggling 1/0 each cycle with y_in=1 for 32 cycles -> exactly one commit, res_count=16, phase advances only on en=1 cycles.
REQ-035 clear=1 at phase=7 -> busy=0 and phase=0 next cycle; the next window counts from zero. Separately, rst pulsed mid-cycle at phase=10 -> all outputs are zero with no clock edge.
REQ-036 res_ready=1 on the same cycle as a commit while res_valid=1 -> the new count is loaded, res_valid stays 1, overrun stays 0.
